// File: rtl/uart_txrx_if.sv
// Bundles the transmit handshake, serial lines and receive strobe of uart_txrx.
// The master side drives requests and rxd, and the slave side is the transceiver.
interface uart_txrx_if #(
  parameter int unsigned WIDTH = 8
);
  logic             rxd;
  logic             start;
  logic [WIDTH-1:0] data_tx;
  logic             txd;
  logic             busy;
  logic             re;
  logic [WIDTH-1:0] data_rx;

  modport master (
    output rxd,
    output start,
    output data_tx,
    input  txd,
    input  busy,
    input  re,
    input  data_rx
  );

  modport slave (
    input  rxd,
    input  start,
    input  data_tx,
    output txd,
    output busy,
    output re,
    output data_rx
  );
endinterface

// File: rtl/uart_txrx.sv
// Full-duplex 8N1-style UART: independent TX and RX state machines share only the clock,
// the synchronous reset and the clocks-per-bit divider constant.
module uart_txrx #(
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned SCLK_HZ = 5000000,
  parameter int unsigned WIDTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  uart_txrx_if.slave  bus
);

  localparam int unsigned Cpb  = CLK_HZ / SCLK_HZ;
  localparam int unsigned CntW = $clog2(Cpb);
  localparam int unsigned BitW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(Cpb - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(Cpb / 2 - 1);
  localparam logic [BitW-1:0] BitMax  = BitW'(WIDTH - 1);

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxWaitHigh} rx_state_e;

  tx_state_e        tx_state_q, tx_state_d;
  logic [CntW-1:0]  tx_cnt_q, tx_cnt_d;
  logic [BitW-1:0]  tx_bit_q, tx_bit_d;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic             txd_c;

  rx_state_e        rx_state_q, rx_state_d;
  logic [CntW-1:0]  rx_cnt_q, rx_cnt_d;
  logic [BitW-1:0]  rx_bit_q, rx_bit_d;
  logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] data_rx_q, data_rx_d;
  logic             re_q, re_d;
  logic [1:0]       sync_q;
  logic             rx_s;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      data_rx_q  <= '0;
      re_q       <= 1'b0;
      sync_q     <= 2'b11;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      data_rx_q  <= data_rx_d;
      re_q       <= re_d;
      sync_q     <= {sync_q[0], bus.rxd};
    end
  end

  // txd is decoded from registered state, so it is glitch-free and idles high after reset.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_c      = 1'b1;
    unique case (tx_state_q)
      TxIdle: begin
        if (bus.start) begin
          tx_state_d = TxStart;
          tx_shift_d = bus.data_tx;
          tx_cnt_d   = '0;
        end
      end
      TxStart: begin
        txd_c = 1'b0;
        if (tx_cnt_q == CntMax) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TxData;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TxData: begin
        txd_c = tx_shift_q[0];
        if (tx_cnt_q == CntMax) begin
          tx_cnt_d   = '0;
          tx_shift_d = tx_shift_q >> 1;
          if (tx_bit_q == BitMax) begin
            tx_state_d = TxStop;
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TxStop: begin
        if (tx_cnt_q == CntMax) begin
          tx_cnt_d   = '0;
          tx_state_d = TxIdle;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    data_rx_d  = data_rx_q;
    re_d       = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        if (!rx_s) begin
          rx_state_d = RxStart;
          rx_cnt_d   = '0;
        end
      end
      RxStart: begin
        // Mid-start-bit recheck rejects short low glitches.
        if (rx_cnt_q == CntHalf) begin
          rx_cnt_d = '0;
          if (rx_s) begin
            rx_state_d = RxIdle;
          end else begin
            rx_state_d = RxData;
            rx_bit_d   = '0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxData: begin
        if (rx_cnt_q == CntMax) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s, rx_shift_q[WIDTH-1:1]};
          if (rx_bit_q == BitMax) begin
            rx_state_d = RxStop;
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxStop: begin
        if (rx_cnt_q == CntMax) begin
          rx_cnt_d = '0;
          if (rx_s) begin
            data_rx_d  = rx_shift_q;
            re_d       = 1'b1;
            rx_state_d = RxIdle;
          end else begin
            rx_state_d = RxWaitHigh;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxWaitHigh: begin
        if (rx_s) begin
          rx_state_d = RxIdle;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  assign bus.txd     = txd_c;
  assign bus.busy    = (tx_state_q != TxIdle);
  assign bus.re      = re_q;
  assign bus.data_rx = data_rx_q;

endmodule

// File: tb/tb_uart_txrx.sv
// Self-checking bench for uart_txrx: frame-level reference model for TX waveforms,
// and a queue of received words compared against the words each scenario sends.
module tb_uart_txrx;
  localparam int unsigned W     = 8;
  localparam int unsigned CPB   = 10;
  localparam int unsigned FRAME = (W + 2) * CPB;

  logic clk = 1'b0;
  logic reset;
  logic loop_en;
  logic rxd_drv;

  always #5 clk = ~clk;

  uart_txrx_if #(.WIDTH(W)) u_if ();
  assign u_if.rxd = loop_en ? u_if.txd : rxd_drv;

  uart_txrx #(
    .CLK_HZ (50000000),
    .SCLK_HZ(5000000),
    .WIDTH  (W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (u_if.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] rx_q[$];
  logic re_prev = 1'b0;
  logic [W-1:0] last_rx = '0;

  // Line level k clocks into a frame: start 0, data LSB first, stop 1.
  function automatic logic frame_bit(input logic [W-1:0] d, input int k);
    int idx;
    idx = k / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= W) return d[idx-1];
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      re_prev = 1'b0;
    end else begin
      if (u_if.re) begin
        rx_q.push_back(u_if.data_rx);
        checks++;
        if (re_prev) begin
          errors++;
          $display("FAIL re_pulse_width: re high on consecutive cycles, got 1 want 0");
        end
      end
      re_prev = u_if.re;
    end
  end

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic tx_launch(input logic [W-1:0] d);
    @(negedge clk);
    u_if.start   = 1'b1;
    u_if.data_tx = d;
  endtask

  // Follows one frame from the cycle after acceptance; optionally chains the next start.
  task automatic tx_watch(input logic [W-1:0] d, input int poke_at, input logic [W-1:0] poke_d,
                          input logic chain, input logic [W-1:0] chain_d, input string name);
    for (int k = 0; k < int'(FRAME); k++) begin
      @(negedge clk);
      checks++;
      if ({u_if.busy, u_if.txd} !== {1'b1, frame_bit(d, k)}) begin
        errors++;
        $display("FAIL %s k=%0d: busy,txd got %b%b want 1%b", name, k, u_if.busy, u_if.txd,
                 frame_bit(d, k));
      end
      u_if.start   = (k == poke_at);
      u_if.data_tx = (k == poke_at) ? poke_d : ~d;
    end
    @(negedge clk);
    checks++;
    if ({u_if.busy, u_if.txd} !== 2'b01) begin
      errors++;
      $display("FAIL %s end: busy,txd got %b%b want 01", name, u_if.busy, u_if.txd);
    end
    u_if.start   = chain;
    u_if.data_tx = chain_d;
  endtask

  task automatic rx_frame(input logic [W-1:0] d, input logic stop);
    for (int k = 0; k < int'(FRAME); k++) begin
      @(negedge clk);
      rxd_drv = (k >= int'((W + 1) * CPB)) ? stop : frame_bit(d, k);
    end
  endtask

  task automatic check_rx(input int n, input logic [W-1:0] e0, input logic [W-1:0] e1,
                          input string name);
    for (int c = 0; c < 3 * int'(CPB) && rx_q.size() < n; c++) @(negedge clk);
    idle_cycles(3);
    checks++;
    if (rx_q.size() != n) begin
      errors++;
      $display("FAIL %s count: re pulses got %0d want %0d", name, rx_q.size(), n);
    end else begin
      if (n > 0) begin
        checks++;
        if (rx_q[0] !== e0) begin
          errors++;
          $display("FAIL %s word0: got %02h want %02h", name, rx_q[0], e0);
        end
      end
      if (n > 1) begin
        checks++;
        if (rx_q[1] !== e1) begin
          errors++;
          $display("FAIL %s word1: got %02h want %02h", name, rx_q[1], e1);
        end
      end
    end
    if (n > 0) last_rx = (n > 1) ? e1 : e0;
    checks++;
    if (u_if.data_rx !== last_rx) begin
      errors++;
      $display("FAIL %s data_rx: got %02h want %02h", name, u_if.data_rx, last_rx);
    end
    rx_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    loop_en = 1'b0;
    rxd_drv = 1'b1;
    u_if.start = 1'b0;
    u_if.data_tx = '0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i == 10) reset = 1'b0;
      checks++;
      if ({u_if.txd, u_if.busy, u_if.re, u_if.data_rx} !== {3'b100, {W{1'b0}}}) begin
        errors++;
        $display("FAIL reset i=%0d: txd,busy,re,data_rx got %b%b%b %02h want 100 00", i,
                 u_if.txd, u_if.busy, u_if.re, u_if.data_rx);
      end
    end
    idle_cycles(2);
    checks++;
    if ({u_if.txd, u_if.busy, u_if.re, u_if.data_rx} !== {3'b100, {W{1'b0}}}) begin
      errors++;
      $display("FAIL reset_release: got %b%b%b %02h want 100 00", u_if.txd, u_if.busy, u_if.re,
               u_if.data_rx);
    end
  endtask

  task automatic test_tx_single();
    tx_launch(8'h41);
    tx_watch(8'h41, -1, '0, 1'b0, '0, "tx_0x41");
    idle_cycles(3);
    tx_launch(8'h41);
    tx_watch(8'h41, 30, 8'hFF, 1'b0, '0, "tx_ignore_start");
    idle_cycles(3);
    for (int i = 0; i < 3; i++) begin
      logic [W-1:0] d;
      d = W'($urandom);
      tx_launch(d);
      tx_watch(d, int'($urandom_range(1, FRAME - 2)), W'($urandom), 1'b0, '0, "tx_random");
      idle_cycles(int'($urandom_range(0, 5)));
    end
  endtask

  task automatic test_back_to_back();
    loop_en = 1'b1;
    rx_q.delete();
    idle_cycles(5);
    tx_launch(8'h55);
    tx_watch(8'h55, -1, '0, 1'b1, 8'hA5, "b2b_first");
    tx_watch(8'hA5, -1, '0, 1'b0, '0, "b2b_second");
    check_rx(2, 8'h55, 8'hA5, "b2b_rx");
    for (int i = 0; i < 3; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = W'($urandom);
      b = W'($urandom);
      tx_launch(a);
      tx_watch(a, -1, '0, 1'b1, b, "loop_rand_a");
      tx_watch(b, -1, '0, 1'b0, '0, "loop_rand_b");
      check_rx(2, a, b, "loop_rand_rx");
    end
    loop_en = 1'b0;
    rxd_drv = 1'b1;
    idle_cycles(5);
  endtask

  task automatic test_glitch();
    rx_q.delete();
    rxd_drv = 1'b0;
    idle_cycles(3);
    rxd_drv = 1'b1;
    idle_cycles(3 * CPB);
    check_rx(0, '0, '0, "glitch");
    rx_frame(8'h3C, 1'b1);
    check_rx(1, 8'h3C, '0, "after_glitch");
  endtask

  task automatic test_break();
    rx_q.delete();
    rx_frame(8'h12, 1'b0);
    idle_cycles(30);
    rxd_drv = 1'b1;
    idle_cycles(2 * CPB);
    check_rx(0, '0, '0, "bad_stop");
    rx_frame(8'h34, 1'b1);
    check_rx(1, 8'h34, '0, "after_break");
    for (int i = 0; i < 3; i++) begin
      logic [W-1:0] d;
      d = W'($urandom);
      rx_frame(d, 1'b1);
      idle_cycles(int'($urandom_range(0, 12)));
      check_rx(1, d, '0, "rx_random");
    end
  endtask

  task automatic test_reset_midframe();
    tx_launch(8'h00);
    @(negedge clk);
    u_if.start = 1'b0;
    idle_cycles(35);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({u_if.txd, u_if.busy} !== 2'b10) begin
      errors++;
      $display("FAIL reset_midframe: txd,busy got %b%b want 10", u_if.txd, u_if.busy);
    end
    last_rx = '0;
    idle_cycles(3);
    checks++;
    if (u_if.data_rx !== last_rx) begin
      errors++;
      $display("FAIL reset_midframe data_rx: got %02h want 00", u_if.data_rx);
    end
  endtask

  initial begin
    test_reset();
    test_tx_single();
    test_back_to_back();
    test_glitch();
    test_break();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_txrx.md
Name: uart_txrx

Overview:
- Full-duplex asynchronous serial transceiver: 8N1-style framing, LSB first, parameterised data width.
- Used by the SoC for its console port, and in benches as a receiver that decodes the SoC's transmit line and strobes each received byte.
- TX and RX are independent and share only the clock, reset and bit-rate divider constant.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- SCLK_HZ, 5000000, serial bit rate in bit/s. CPB = CLK_HZ/SCLK_HZ (integer division) is the clocks per bit; CPB must be >= 4.
- WIDTH, 8, data bits per frame.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- rxd  input  1  serial receive line, asynchronous, idle high.
- start  input  1  one-cycle request to transmit data_tx.
- data_tx  input  WIDTH  byte to transmit, sampled when start is accepted.
- txd  output  1  serial transmit line, idle high.
- busy  output  1  transmitter busy flag.
- re  output  1  one-cycle strobe: data_rx holds a newly received valid frame.
- data_rx  output  WIDTH  last correctly received data word.

Behaviour:
- Reset values: txd=1, busy=0, re=0, data_rx=0. Both FSMs go to IDLE, counters are cleared, and the RX synchroniser is set to 1. Reset mid-frame aborts the frame; txd is high on the next cycle.
- Frame format: 1 start bit (0), WIDTH data bits LSB first, 1 stop bit (1). Every bit is exactly CPB clocks.

TX FSM (IDLE, START, DATA, STOP):
- start is accepted in any cycle where busy=0 and start=1 (cycle N); data_tx is latched that cycle.
- Cycle N+1: busy=1, txd=0 (start bit).
- Data bits follow, then the stop bit.
- busy falls at N+1+(WIDTH+2)*CPB; txd is 1 from the stop bit onward.
- start while busy=1 is ignored (no queueing).
- Back-to-back: start in the first cycle busy=0 is accepted, so there is no extra idle gap.

RX FSM (IDLE, START, DATA, STOP, WAIT_HIGH):
- rxd passes through a 2-flop synchroniser; all decisions use the synchronised value.
- IDLE → START on synchronised rxd = 0.
- At CPB/2 clocks after entering START, rxd is re-sampled:
  - if 1, the event is treated as a glitch and the FSM returns to IDLE;
  - if 0, it proceeds.
- Each data bit is sampled CPB clocks after the previous sample (mid-bit) and shifted in LSB first.
- Stop sample = 1: data_rx is updated and re=1 for exactly one cycle in the same cycle data_rx changes. The FSM then returns to IDLE.
- Stop sample = 0 (framing error/break): no re, data_rx is unchanged, and the FSM goes to WAIT_HIGH. It stays there until synchronised rxd = 1, then goes to IDLE.
- data_rx holds its value between frames. re is never high on consecutive cycles.
- RX operates simultaneously with TX; loopback (txd→rxd) must work.

Test Plan:
- Reset with rxd=1, start=0 for 10 cycles → txd=1, busy=0, re=0, data_rx=0 throughout and after release.
- CPB=10, start=1 with data_tx=0x41 for one cycle → txd shows 0,1,0,0,0,0,0,1,0,1, each bit 10 cycles; busy high for exactly 100 cycles starting the cycle after start.
- Loopback txd→rxd, send 0x55 then 0xA5 back-to-back (start pulsed the first cycle busy=0) → exactly two re pulses; data_rx=0x55 then 0xA5; second frame's start bit immediately follows the first frame's stop bit.
- start pulsed again 30 cycles into a 0x41 frame with data_tx=0xFF → ignored; waveform and busy timing identical to the single-frame case.
- rxd driven low 3 cycles then high (CPB=10) → no re, RX back in IDLE; a following valid 0x3C frame is received with re pulse and data_rx=0x3C.
- Frame 0x12 with stop bit 0, rxd held low 30 more cycles, then a valid 0x34 frame → no re for the bad frame, data_rx stays at its previous value, then one re with data_rx=0x34.
